csc_rgb_packer: RTL
===================

Name: csc_rgb_packer

Overview:
Colour-space conversion and RGB packing stage of the decompressor datapath. It consumes upsampled Y/U/V sample triples one pixel at a time and converts each to 8-bit RGB with fixed-point arithmetic and clipping. It packs pixel pairs into three 16-bit words and writes them sequentially into the RGB segment of external SRAM, which the VGA unit reads. The top-level FSM grants it the SRAM port; it sits directly downstream of the upsampling datapath.

Parameters:
RGB_BASE_ADDR, 18'd146944, SRAM word address of the first RGB word.
PIXEL_COUNT, 76800, number of pixels per frame (320x240); must be even.
FRAC_BITS, 16, fractional bits of the CSC coefficients.

Ports:
Clock  input  1  system clock, 50 MHz
resetn  input  1  asynchronous active-low reset
start  input  1  level from the top FSM; a rising edge begins one frame
pix_valid  input  1  Y_in/U_in/V_in hold a valid pixel
pix_ready  output  1  block accepts the pixel this cycle
Y_in  input  8  luma, unsigned
U_in  input  8  Cb, unsigned
V_in  input  8  Cr, unsigned
SRAM_address  output  18  write address
SRAM_write_data  output  16  packed RGB word
SRAM_we_n  output  1  active-low write strobe
stop  output  1  one-cycle pulse when the last word is written

Behaviour:
- Reset values: pix_ready=0, SRAM_we_n=1, SRAM_address=RGB_BASE_ADDR, SRAM_write_data=0, stop=0. All pipeline registers, counters and the FSM are cleared. Reset mid-frame abandons the frame; no further writes occur.
- start is registered (start_q). The frame begins only on start & ~start_q while in S_IDLE. A level held high after stop does not retrigger.
- FSM states:
  - S_IDLE: on the rising edge of start -> S_RUN. Clear the pixel counter, word counter and phase; load the address with RGB_BASE_ADDR.
  - S_RUN: accept pixels. When PIXEL_COUNT pixels have been accepted and the final bubble has been issued -> S_DRAIN.
  - S_DRAIN: pix_ready=0. Wait until the pipeline is empty and the final word is written -> S_DONE.
  - S_DONE: assert stop for 1 cycle -> S_IDLE.
- Input phase counter (mod 3):
  - Phase 0 accepts the even pixel; phase 1 accepts the odd pixel. pix_ready=1 in both phases while in S_RUN.
  - Phase 2 is a forced bubble: pix_ready=0, and a bubble token enters the pipeline unconditionally.
  - The phase advances from 0 or 1 only on pix_valid & pix_ready. Phase 2 always advances to 0 next cycle.
- CSC arithmetic, signed 32-bit:
  - y=Y-16, u=U-128, v=V-128.
  - R = 76284y + 104595v
  - G = 76284y - 25624u - 53281v
  - B = 76284y + 132251u
  - Each result is arithmetic-shifted right by FRAC_BITS (truncation). Negative values clip to 0; values >255 clip to 255.
- Pipeline: 3 stages (offset/multiply, accumulate, shift/clip). Tokens carry a tag: EVEN, ODD or BUBBLE.
- Write stage, registered, 1 cycle after pipeline exit:
  - EVEN: write {R0,G0}; hold B0.
  - ODD: write {B0,R1}; hold G1,B1.
  - BUBBLE: write {G1,B1}.
  - Empty slot (no valid token): SRAM_we_n=1.
- Latency: pixel acceptance to its first dependent write is 4 cycles.
- SRAM_address increments by 1 after each write. Exactly 3*PIXEL_COUNT/2 words are written per frame; the last address is RGB_BASE_ADDR + 3*PIXEL_COUNT/2 - 1.
- Throughput: at most 2 pixels per 3 cycles. pix_valid gaps only delay the pattern; they never reorder words.
- pix_valid while pix_ready=0, or outside S_RUN, is ignored and the data is not consumed.

Optional Feature:
Macro CSC_CLIP_COUNT_EN.
- Defined: adds output port clip_count (17 bits). It counts colour components clipped (R, G and B counted separately) in the current frame. It clears on frame start, saturates at all-ones, and holds its value after stop until the next start.
- Undefined: the port and counter are absent. Behaviour is otherwise identical.

Decomposition:
- Shared package csc_pkg holds:
  - coefficient localparams (76284, 104595, 25624, 53281, 132251), plus Y offset 16 and chroma offset 128;
  - enum csc_state_type (S_IDLE, S_RUN, S_DRAIN, S_DONE);
  - enum tag_type (EVEN, ODD, BUBBLE).
- One natural sub-module: csc_core, the 3-stage YUV->RGB pipeline with clip, carrying a valid bit and tag. The packing, addressing and FSM stay in the parent.

Test Plan:
- Reset mid-frame after 5 words -> SRAM_we_n=1 immediately; address=146944; no stop pulse. A following start rising edge restarts at 146944.
- PIXEL_COUNT=2, pixels (235,128,128),(16,128,128) continuous -> writes 0xFEFE@146944, 0xFE00@146945, 0x0000@146946; stop pulses 1 cycle after the last write.
- Pixel (128,128,128) pair -> every word 0x8282. Pixel (255,128,255) -> R clipped to 0xFF. Pixel (0,128,128) -> RGB 0x00 (clip low).
- pix_valid toggling 1-0-1-0 across 4 pixels -> pix_ready=0 every third phase only. Word sequence and addresses are identical to the continuous case.
- Full frame, PIXEL_COUNT=76800 -> 115200 writes; last address 262143; start held high after stop -> no second frame.
- With CSC_CLIP_COUNT_EN: the (255,128,255) and (0,128,128) pair -> clip_count=5 (R,B of pixel 1; R,G,B of pixel 2).

Source files
------------

// File: rtl/csc_pkg.sv
// csc_pkg: shared constants, state/tag enums and the clip helper for the YUV->RGB stage.
package csc_pkg;

   localparam int signed C_Y      = 76284;
   localparam int signed C_RV     = 104595;
   localparam int signed C_GU     = 25624;
   localparam int signed C_GV     = 53281;
   localparam int signed C_BU     = 132251;
   localparam int signed Y_OFFSET = 16;
   localparam int signed C_OFFSET = 128;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} csc_state_type;
   typedef enum logic [1:0] {EVEN, ODD, BUBBLE} tag_type;

   // Returns {clipped, value}; the shifted accumulator is clamped to 0..255.
   function automatic logic [8:0] clip_u8(input logic signed [31:0] x);
      if (x < 0)
         return {1'b1, 8'h00};
      else if (x > 255)
         return {1'b1, 8'hFF};
      else
         return {1'b0, x[7:0]};
   endfunction

endpackage

// File: rtl/csc_core.sv
// csc_core: three-stage YUV->RGB pipeline (offset/multiply, accumulate, shift/clip)
// carrying a valid bit and tag; clip flags exist only with CSC_CLIP_COUNT_EN.
module csc_core
   import csc_pkg::*;
#(
   parameter int FRAC_BITS = 16
) (
   input  logic       Clock,
   input  logic       resetn,
   input  logic       in_valid,
   input  tag_type    in_tag,
   input  logic [7:0] y_in,
   input  logic [7:0] u_in,
   input  logic [7:0] v_in,
   output logic       out_valid,
   output tag_type    out_tag,
   output logic [7:0] r_out,
   output logic [7:0] g_out,
   output logic [7:0] b_out,
`ifdef CSC_CLIP_COUNT_EN
   output logic [2:0] clip_flags,
`endif
   output logic       busy
);

   logic signed [31:0] y_s, u_s, v_s;
   logic               v1, v2;
   tag_type            tag1, tag2;
   logic signed [31:0] p_y, p_rv, p_gu, p_gv, p_bu;
   logic signed [31:0] acc_r, acc_g, acc_b;
   logic [8:0]         clip_r, clip_g, clip_b;

   always_comb begin
      y_s = $signed({24'd0, y_in}) - Y_OFFSET;
      u_s = $signed({24'd0, u_in}) - C_OFFSET;
      v_s = $signed({24'd0, v_in}) - C_OFFSET;
   end

   always_ff @(posedge Clock or negedge resetn) begin
      if (!resetn) begin
         v1   <= 1'b0;
         tag1 <= EVEN;
         p_y  <= '0;
         p_rv <= '0;
         p_gu <= '0;
         p_gv <= '0;
         p_bu <= '0;
      end else begin
         v1   <= in_valid;
         tag1 <= in_tag;
         p_y  <= y_s * C_Y;
         p_rv <= v_s * C_RV;
         p_gu <= u_s * C_GU;
         p_gv <= v_s * C_GV;
         p_bu <= u_s * C_BU;
      end
   end

   always_ff @(posedge Clock or negedge resetn) begin
      if (!resetn) begin
         v2    <= 1'b0;
         tag2  <= EVEN;
         acc_r <= '0;
         acc_g <= '0;
         acc_b <= '0;
      end else begin
         v2    <= v1;
         tag2  <= tag1;
         acc_r <= p_y + p_rv;
         acc_g <= p_y - p_gu - p_gv;
         acc_b <= p_y + p_bu;
      end
   end

   always_comb begin
      clip_r = clip_u8(acc_r >>> FRAC_BITS);
      clip_g = clip_u8(acc_g >>> FRAC_BITS);
      clip_b = clip_u8(acc_b >>> FRAC_BITS);
   end

   always_ff @(posedge Clock or negedge resetn) begin
      if (!resetn) begin
         out_valid  <= 1'b0;
         out_tag    <= EVEN;
         r_out      <= '0;
         g_out      <= '0;
         b_out      <= '0;
`ifdef CSC_CLIP_COUNT_EN
         clip_flags <= '0;
`endif
      end else begin
         out_valid  <= v2;
         out_tag    <= tag2;
         r_out      <= clip_r[7:0];
         g_out      <= clip_g[7:0];
         b_out      <= clip_b[7:0];
`ifdef CSC_CLIP_COUNT_EN
         clip_flags <= {clip_b[8], clip_g[8], clip_r[8]};
`endif
      end
   end

   assign busy = v1 | v2 | out_valid;

endmodule

// File: rtl/csc_rgb_packer.sv
// csc_rgb_packer: frame FSM, pixel-pair packing into three 16-bit RGB words and SRAM writes.
// Optional CSC_CLIP_COUNT_EN adds the per-frame clip_count output.
module csc_rgb_packer
   import csc_pkg::*;
#(
   parameter logic [17:0] RGB_BASE_ADDR = 18'd146944,
   parameter int unsigned PIXEL_COUNT   = 76800,
   parameter int          FRAC_BITS     = 16
) (
   input  logic        Clock,
   input  logic        resetn,
   input  logic        start,
   input  logic        pix_valid,
   output logic        pix_ready,
   input  logic [7:0]  Y_in,
   input  logic [7:0]  U_in,
   input  logic [7:0]  V_in,
   output logic [17:0] SRAM_address,
   output logic [15:0] SRAM_write_data,
   output logic        SRAM_we_n,
   output logic        stop
`ifdef CSC_CLIP_COUNT_EN
   ,
   output logic [16:0] clip_count
`endif
);

   localparam int unsigned WORDS  = 3 * PIXEL_COUNT / 2;
   localparam int unsigned PIX_W  = $clog2(PIXEL_COUNT + 1);
   localparam int unsigned WORD_W = $clog2(WORDS + 1);

   csc_state_type     state;
   tag_type           phase;
   logic              start_q, frame_start;
   logic [PIX_W-1:0]  pix_cnt;
   logic [WORD_W-1:0] word_cnt;
   logic [17:0]       wr_addr;
   logic [7:0]        hold_b0, hold_g1, hold_b1;
   logic              core_in_valid, core_valid, core_busy;
   tag_type           core_tag;
   logic [7:0]        core_r, core_g, core_b;
`ifdef CSC_CLIP_COUNT_EN
   logic [2:0]        core_clip;
   logic [17:0]       clip_sum;
`endif

   assign frame_start   = (state == S_IDLE) && start && !start_q;
   // The bubble slot always enters the pipeline; it emits the third word of each pair.
   assign core_in_valid = (state == S_RUN) && ((phase == BUBBLE) || (pix_valid && pix_ready));

   csc_core #(
      .FRAC_BITS(FRAC_BITS)
   ) u_core (
      .Clock     (Clock),
      .resetn    (resetn),
      .in_valid  (core_in_valid),
      .in_tag    (phase),
      .y_in      (Y_in),
      .u_in      (U_in),
      .v_in      (V_in),
      .out_valid (core_valid),
      .out_tag   (core_tag),
      .r_out     (core_r),
      .g_out     (core_g),
      .b_out     (core_b),
`ifdef CSC_CLIP_COUNT_EN
      .clip_flags(core_clip),
`endif
      .busy      (core_busy)
   );

   always_ff @(posedge Clock or negedge resetn) begin
      if (!resetn) begin
         state     <= S_IDLE;
         phase     <= EVEN;
         start_q   <= 1'b0;
         pix_ready <= 1'b0;
         stop      <= 1'b0;
         pix_cnt   <= '0;
      end else begin
         start_q <= start;
         stop    <= 1'b0;
         case (state)
            S_IDLE: begin
               if (frame_start) begin
                  state     <= S_RUN;
                  phase     <= EVEN;
                  pix_cnt   <= '0;
                  pix_ready <= 1'b1;
               end
            end
            S_RUN: begin
               if (phase == BUBBLE) begin
                  phase <= EVEN;
                  if (pix_cnt == PIX_W'(PIXEL_COUNT)) begin
                     state     <= S_DRAIN;
                     pix_ready <= 1'b0;
                  end else begin
                     pix_ready <= 1'b1;
                  end
               end else if (pix_valid && pix_ready) begin
                  pix_cnt <= pix_cnt + 1'b1;
                  if (phase == ODD) begin
                     phase     <= BUBBLE;
                     pix_ready <= 1'b0;
                  end else begin
                     phase <= ODD;
                  end
               end
            end
            S_DRAIN: begin
               if (word_cnt == WORD_W'(WORDS) && !core_busy) begin
                  state <= S_DONE;
                  stop  <= 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Pair packing: EVEN -> {R0,G0}, ODD -> {B0,R1}, BUBBLE -> {G1,B1}.
   always_ff @(posedge Clock or negedge resetn) begin
      if (!resetn) begin
         SRAM_we_n       <= 1'b1;
         SRAM_write_data <= '0;
         SRAM_address    <= RGB_BASE_ADDR;
         wr_addr         <= RGB_BASE_ADDR;
         word_cnt        <= '0;
         hold_b0         <= '0;
         hold_g1         <= '0;
         hold_b1         <= '0;
      end else begin
         SRAM_we_n <= 1'b1;
         if (frame_start) begin
            SRAM_address <= RGB_BASE_ADDR;
            wr_addr      <= RGB_BASE_ADDR;
            word_cnt     <= '0;
         end else if (core_valid) begin
            SRAM_we_n    <= 1'b0;
            SRAM_address <= wr_addr;
            wr_addr      <= wr_addr + 18'd1;
            word_cnt     <= word_cnt + 1'b1;
            case (core_tag)
               EVEN: begin
                  SRAM_write_data <= {core_r, core_g};
                  hold_b0         <= core_b;
               end
               ODD: begin
                  SRAM_write_data <= {hold_b0, core_r};
                  hold_g1         <= core_g;
                  hold_b1         <= core_b;
               end
               default: SRAM_write_data <= {hold_g1, hold_b1};
            endcase
         end
      end
   end

`ifdef CSC_CLIP_COUNT_EN
   always_comb
      clip_sum = {1'b0, clip_count} + {17'd0, core_clip[0]}
               + {17'd0, core_clip[1]} + {17'd0, core_clip[2]};

   always_ff @(posedge Clock or negedge resetn) begin
      if (!resetn)
         clip_count <= '0;
      else if (frame_start)
         clip_count <= '0;
      else if (core_valid && core_tag != BUBBLE)
         clip_count <= clip_sum[17] ? '1 : clip_sum[16:0];
   end
`endif

endmodule
